// File: rtl/branch_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding and allocation values.
package branch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET    = WNT;
    localparam ctr_t CTR_ALLOC_T  = WT;
    localparam ctr_t CTR_ALLOC_NT = WNT;

endpackage

// File: rtl/sat_counter2.sv
// Next-state of a 2-bit saturating direction counter (SNT <-> WNT <-> WT <-> ST).
module sat_counter2
    import branch_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != ST) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT/BTB lookup at fetch, branch/jump resolution and training at execute.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_W   = 9,
    parameter int IDX_W  = 4,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    output logic [31:0]       if_pred_target,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic [31:0]       ex_alu_result,
    input  logic              ex_branch,
    input  logic              ex_jal,
    input  logic              ex_jalr,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic [31:0]       ex_pc_four,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        ctr_t             ctr;
        logic [31:0]      target;
    } bp_entry_t;

    bp_entry_t entries_q [DEPTH];
    bp_entry_t entries_d [DEPTH];
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

    // Fetch-side lookup reads registered contents only, so a same-cycle update is not visible.
    logic [31:0]      if_pc32;
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    bp_entry_t        if_ent;
    logic             if_hit;

    assign if_pc32        = {{(32-PC_W){1'b0}}, if_pc};
    assign if_idx         = if_pc[IDX_W+1:2];
    assign if_tag         = if_pc[PC_W-1:IDX_W+2];
    assign if_ent         = entries_q[if_idx];
    assign if_hit         = if_ent.valid && (if_ent.tag == if_tag);
    assign if_pred_taken  = if_hit && if_ent.ctr[1];
    assign if_pred_target = if_pred_taken ? if_ent.target : if_pc32 + 32'd4;

    logic [31:0]      ex_pc32;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    bp_entry_t        ex_ent;
    logic             cf;
    logic             taken;
    logic [31:0]      act_target;
    logic [31:0]      act_next;
    logic [1:0]       ctr_nxt;

    assign ex_pc32    = {{(32-PC_W){1'b0}}, ex_pc};
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign ex_tag     = ex_pc[PC_W-1:IDX_W+2];
    assign ex_ent     = entries_q[ex_idx];
    assign ex_pc_four = ex_pc32 + 32'd4;
    assign cf         = ex_valid && (ex_branch || ex_jal || ex_jalr);
    assign taken      = ex_jal || ex_jalr || (ex_branch && ex_alu_result[0]);
    assign act_target = ex_jalr ? {ex_alu_result[31:1], 1'b0} : ex_pc32 + ex_imm;
    assign act_next   = taken ? act_target : ex_pc_four;

    // Comparing the full next PC also catches a non-control-flow instruction that aliased
    // onto a taken entry; ex_pred_taken is implied by the target and carries no extra info.
    assign mispredict  = reset && ex_valid && (ex_pred_target != act_next);
    assign redirect_pc = mispredict ? act_next : 32'd0;

    sat_counter2 u_ctr (
        .ctr     (ex_ent.ctr),
        .taken   (taken),
        .ctr_nxt (ctr_nxt)
    );

    always_comb begin
        entries_d = entries_q;
        if (cf) begin
            if (ex_ent.valid && ex_ent.tag == ex_tag) begin
                entries_d[ex_idx].ctr = ctr_t'(ctr_nxt);
            end else begin
                entries_d[ex_idx].valid = 1'b1;
                entries_d[ex_idx].tag   = ex_tag;
                entries_d[ex_idx].ctr   = taken ? CTR_ALLOC_T : CTR_ALLOC_NT;
            end
            if (taken) entries_d[ex_idx].target = act_target;
        end else if (mispredict) begin
            entries_d[ex_idx].valid = 1'b0;
        end
    end

    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (cf && perf_br_q != {PERF_W{1'b1}}) perf_br_d = perf_br_q + 1'b1;
        if (mispredict && perf_mp_q != {PERF_W{1'b1}}) perf_mp_d = perf_mp_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_RESET, target: 32'd0};
            end
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            entries_q <= entries_d;
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vector bench for branch_predict_unit, plus reset and counter-saturation sequences.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [8:0]  if_pc = 9'h10;
    logic        ex_valid = 1'b0;
    logic [8:0]  ex_pc = 9'h0;
    logic [31:0] ex_imm = 32'd0;
    logic [31:0] ex_alu_result = 32'd0;
    logic        ex_branch = 1'b0, ex_jal = 1'b0, ex_jalr = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'd0;

    logic        if_pred_taken, mispredict;
    logic [31:0] if_pred_target, ex_pc_four, redirect_pc;
    logic [31:0] perf_branches, perf_mispredicts;

    logic        s_pt, s_mis;
    logic [31:0] s_ptgt, s_pf, s_red;
    logic [1:0]  s_pb, s_pm;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(9), .IDX_W(4), .PERF_W(32)) u_dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_pc_four(ex_pc_four), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    // Narrow-counter instance on the same stimulus, used to reach saturation quickly.
    branch_predict_unit #(.PC_W(9), .IDX_W(4), .PERF_W(2)) u_small (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .if_pred_taken(s_pt), .if_pred_target(s_ptgt),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_pc_four(s_pf), .mispredict(s_mis), .redirect_pc(s_red),
        .perf_branches(s_pb), .perf_mispredicts(s_pm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] ifpc;
        logic        v;
        logic [31:0] pc, imm, alu;
        logic        br, jal, jalr, pt;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_red, e_pf, e_pb, e_pm;
    } vec_t;

    vec_t vecs [15];

    task automatic drive(input vec_t t);
        if_pc          = t.ifpc[8:0];
        ex_valid       = t.v;
        ex_pc          = t.pc[8:0];
        ex_imm         = t.imm;
        ex_alu_result  = t.alu;
        ex_branch      = t.br;
        ex_jal         = t.jal;
        ex_jalr        = t.jalr;
        ex_pred_taken  = t.pt;
        ex_pred_target = t.ptgt;
    endtask

    initial begin
        //          ifpc   v  pc     imm          alu    br jal jalr pt ptgt    e_pt e_ptgt e_mis e_red  e_pf   pb  pm
        vecs[0]  = '{32'h10, 1, 32'h10, 32'h20,       32'h1,  1, 0, 0, 0, 32'h14, 0, 32'h14, 1, 32'h30, 32'h14, 0, 0};
        vecs[1]  = '{32'h10, 1, 32'h10, 32'h20,       32'h1,  1, 0, 0, 1, 32'h30, 1, 32'h30, 0, 32'h0,  32'h14, 1, 1};
        vecs[2]  = '{32'h10, 1, 32'h10, 32'h20,       32'h1,  1, 0, 0, 1, 32'h30, 1, 32'h30, 0, 32'h0,  32'h14, 2, 1};
        vecs[3]  = '{32'h10, 1, 32'h10, 32'h20,       32'h1,  1, 0, 0, 1, 32'h30, 1, 32'h30, 0, 32'h0,  32'h14, 3, 1};
        vecs[4]  = '{32'h10, 1, 32'h10, 32'h20,       32'h0,  1, 0, 0, 1, 32'h30, 1, 32'h30, 1, 32'h14, 32'h14, 4, 1};
        vecs[5]  = '{32'h10, 0, 32'h10, 32'h20,       32'h0,  0, 0, 0, 0, 32'h0,  1, 32'h30, 0, 32'h0,  32'h14, 5, 2};
        vecs[6]  = '{32'h20, 1, 32'h20, 32'h0,        32'h45, 0, 0, 1, 0, 32'h24, 0, 32'h24, 1, 32'h44, 32'h24, 5, 2};
        vecs[7]  = '{32'h20, 1, 32'h20, 32'h0,        32'h45, 0, 0, 1, 1, 32'h44, 1, 32'h44, 0, 32'h0,  32'h24, 6, 3};
        vecs[8]  = '{32'h50, 0, 32'h20, 32'h0,        32'h0,  0, 0, 0, 0, 32'h0,  0, 32'h54, 0, 32'h0,  32'h24, 7, 3};
        vecs[9]  = '{32'h10, 1, 32'h10, 32'h0,        32'h0,  0, 0, 0, 1, 32'h30, 1, 32'h30, 1, 32'h14, 32'h14, 7, 3};
        vecs[10] = '{32'h10, 0, 32'h10, 32'h0,        32'h0,  0, 0, 0, 0, 32'h0,  0, 32'h14, 0, 32'h0,  32'h14, 7, 4};
        vecs[11] = '{32'h10, 1, 32'h10, 32'h20,       32'h1,  1, 0, 0, 0, 32'h14, 0, 32'h14, 1, 32'h30, 32'h14, 7, 4};
        vecs[12] = '{32'h10, 0, 32'h10, 32'h0,        32'h0,  0, 0, 0, 0, 32'h0,  1, 32'h30, 0, 32'h0,  32'h14, 8, 5};
        vecs[13] = '{32'h30, 1, 32'h30, 32'hFFFFFFF8, 32'h0,  0, 1, 0, 0, 32'h34, 0, 32'h34, 1, 32'h28, 32'h34, 8, 5};
        vecs[14] = '{32'h30, 0, 32'h30, 32'h0,        32'h0,  0, 0, 0, 0, 32'h0,  1, 32'h28, 0, 32'h0,  32'h34, 9, 6};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.pt", {31'd0, if_pred_taken}, 32'd0);
        chk("rst.ptgt", if_pred_target, 32'h14);
        chk("rst.pb", perf_branches, 32'd0);
        chk("rst.pm", perf_mispredicts, 32'd0);
        chk("rst.mis", {31'd0, mispredict}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d.pt", i), {31'd0, if_pred_taken}, {31'd0, vecs[i].e_pt});
            chk($sformatf("v%0d.ptgt", i), if_pred_target, vecs[i].e_ptgt);
            chk($sformatf("v%0d.mis", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d.red", i), redirect_pc, vecs[i].e_red);
            chk($sformatf("v%0d.pf", i), ex_pc_four, vecs[i].e_pf);
            chk($sformatf("v%0d.pb", i), perf_branches, vecs[i].e_pb);
            chk($sformatf("v%0d.pm", i), perf_mispredicts, vecs[i].e_pm);
            @(posedge clk); #1;
        end

        // Reset asserted while a taken branch at 0x20 would update the table.
        if_pc = 9'h20; ex_valid = 1'b1; ex_pc = 9'h20; ex_imm = 32'h20; ex_alu_result = 32'h1;
        ex_branch = 1'b1; ex_jal = 1'b0; ex_jalr = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = 32'h24;
        reset = 1'b0;
        @(negedge clk);
        chk("rstupd.mis", {31'd0, mispredict}, 32'd0);
        chk("rstupd.red", redirect_pc, 32'd0);
        chk("rstupd.pt", {31'd0, if_pred_taken}, 32'd0);
        chk("rstupd.pb", perf_branches, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        chk("rstclr.pt20", {31'd0, if_pred_taken}, 32'd0);
        chk("rstclr.ptgt20", if_pred_target, 32'h24);
        if_pc = 9'h30;
        #1;
        chk("rstclr.pt30", {31'd0, if_pred_taken}, 32'd0);
        @(posedge clk); #1;

        // Non-control-flow mispredicts drive the 2-bit counters into saturation.
        ex_valid = 1'b1; ex_pc = 9'h40; ex_branch = 1'b0; ex_pred_target = 32'h99;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sat.small_pm_2", {30'd0, s_pm}, 32'd2);
        chk("sat.big_pm_2", perf_mispredicts, 32'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sat.small_pm_max", {30'd0, s_pm}, 32'd3);
        chk("sat.big_pm_4", perf_mispredicts, 32'd4);
        chk("sat.small_pb", {30'd0, s_pb}, 32'd0);
        ex_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
